// File: rtl/lsu_byte_sequencer.sv
// Byte-serial load/store sequencer: runs one RV32I load or store as N single-byte
// accesses, little-endian, and returns extended load data with a one-cycle response pulse.
module lsu_byte_sequencer #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [2:0]          f3_q, f3_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [1:0]          k_q, k_d;
    logic [31:0]         asm_q, asm_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_q, err_d;

    logic                accept;
    logic                legal;
    logic                last;
    logic [1:0]          k_last;
    logic [31:0]         wdata_shift;

    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] a);
        case (f3)
            3'b000:  extend = {{24{a[7]}}, a[7:0]};
            3'b001:  extend = {{16{a[15]}}, a[15:0]};
            3'b100:  extend = {24'h0, a[7:0]};
            3'b101:  extend = {16'h0, a[15:0]};
            default: extend = a;
        endcase
    endfunction

    assign accept = req_valid && req_ready;

    // Legal funct3 for the direction, then natural alignment for H and W.
    always_comb begin
        if (req_we)
            legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
        else
            legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                    (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
        if (req_funct3[1:0] == 2'b01 && req_addr[0])
            legal = 1'b0;
        if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)
            legal = 1'b0;
    end

    assign k_last      = f3_q[1] ? 2'd3 : {1'b0, f3_q[0]};
    assign last        = (k_q == k_last);
    assign wdata_shift = wdata_q >> {k_q, 3'b000};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            base_q  <= '0;
            wdata_q <= 32'h0;
            k_q     <= 2'd0;
            asm_q   <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            base_q  <= base_d;
            wdata_q <= wdata_d;
            k_q     <= k_d;
            asm_q   <= asm_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = legal ? XFER : DONE;
            XFER:    if (last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Response registers are loaded only on entry to DONE so they hold until the next one.
    always_comb begin
        we_d    = we_q;
        f3_d    = f3_q;
        base_d  = base_q;
        wdata_d = wdata_q;
        k_d     = k_q;
        asm_d   = asm_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        if (state_q == IDLE && accept) begin
            we_d    = req_we;
            f3_d    = req_funct3;
            base_d  = req_addr[ADDR_W-1:0];
            wdata_d = req_wdata;
            k_d     = 2'd0;
            asm_d   = 32'h0;
            if (!legal) begin
                rdata_d = 32'h0;
                err_d   = 1'b1;
            end
        end else if (state_q == XFER) begin
            k_d = k_q + 2'd1;
            if (!we_q)
                asm_d[{k_q, 3'b000} +: 8] = mem_rdata;
            if (last) begin
                rdata_d = we_q ? 32'h0 : extend(f3_q, asm_d);
                err_d   = 1'b0;
            end
        end
    end

    always_comb begin
        req_ready  = (state_q == IDLE) && rst_n;
        busy       = (state_q != IDLE);
        resp_valid = (state_q == DONE);
        resp_rdata = rdata_q;
        resp_err   = err_q;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = 8'h0;
        if (state_q == XFER) begin
            // Reset must suppress the strobe in the very cycle it is asserted.
            mem_we    = we_q && rst_n;
            mem_addr  = base_q + ADDR_W'(k_q);
            mem_wdata = we_q ? wdata_shift[7:0] : 8'h0;
        end
    end

endmodule

// File: tb/tb_lsu_byte_sequencer.sv
module tb_lsu_byte_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err, busy;
    logic [31:0] resp_rdata;
    logic [5:0]  mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata, mem_rdata;
    logic [7:0]  mem [64];

    int checks = 0;
    int errors = 0;
    bit done = 1'b0;

    always #5 clk = ~clk;

    lsu_byte_sequencer #(.ADDR_W(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .busy(busy), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial begin
        for (int i = 0; i < 64; i++) mem[i] <= 8'(i * 3 + 1);
    end
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
    assign mem_rdata = mem[mem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #20000;
        if (!done) begin
            errors++;
            $error("FAIL timeout: simulation did not complete in time");
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input int nb,
                           input logic [31:0] exp_rdata, input logic exp_err);
        int lat;
        logic [5:0] exp_addr;
        lat = (nb == 0) ? 1 : nb + 1;
        @(negedge clk);
        chk("ready_before_req", req_ready, 1'b1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int i = 1; i <= lat; i++) begin
            @(negedge clk);
            if (i < lat) begin
                exp_addr = addr[5:0] + 6'(i - 1);
                chk("xfer_no_resp", resp_valid, 1'b0);
                chk("xfer_mem_we", mem_we, we);
                chk("xfer_mem_addr", mem_addr, exp_addr);
                if (we) chk("xfer_mem_wdata", mem_wdata, wdata[8*(i-1) +: 8]);
            end else begin
                chk("resp_valid", resp_valid, 1'b1);
                chk("resp_rdata", resp_rdata, exp_rdata);
                chk("resp_err", resp_err, exp_err);
                chk("done_mem_we", mem_we, 1'b0);
                chk("done_mem_addr", mem_addr, 6'h00);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", req_ready, 1'b0);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 6'h00);
        chk("rst_mem_wdata", mem_wdata, 8'h00);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_err", resp_err, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        run_req(1'b1, 3'b010, 32'h08, 32'hDEADBEEF, 4, 32'h0, 1'b0);
        chk("sw_mem8", mem[8], 8'hEF);
        chk("sw_mem9", mem[9], 8'hBE);
        chk("sw_mem10", mem[10], 8'hAD);
        chk("sw_mem11", mem[11], 8'hDE);
        run_req(1'b0, 3'b010, 32'h08, 32'h0, 4, 32'hDEADBEEF, 1'b0);

        run_req(1'b0, 3'b000, 32'h0B, 32'h0, 1, 32'hFFFFFFDE, 1'b0);
        run_req(1'b0, 3'b100, 32'h0B, 32'h0, 1, 32'h000000DE, 1'b0);
        run_req(1'b0, 3'b001, 32'h0A, 32'h0, 2, 32'hFFFFDEAD, 1'b0);
        run_req(1'b0, 3'b101, 32'h08, 32'h0, 2, 32'h0000BEEF, 1'b0);

        run_req(1'b0, 3'b010, 32'h09, 32'h0, 0, 32'h0, 1'b1);
        run_req(1'b1, 3'b001, 32'h03, 32'h12345678, 0, 32'h0, 1'b1);
        run_req(1'b1, 3'b100, 32'h08, 32'h12345678, 0, 32'h0, 1'b1);
        run_req(1'b0, 3'b011, 32'h08, 32'h0, 0, 32'h0, 1'b1);
        chk("err_mem8_kept", mem[8], 8'hEF);

        run_req(1'b1, 3'b010, 32'h44, 32'h11223344, 4, 32'h0, 1'b0);
        chk("alias_mem4", mem[4], 8'h44);
        chk("alias_mem7", mem[7], 8'h11);
        run_req(1'b0, 3'b010, 32'h04, 32'h0, 4, 32'h11223344, 1'b0);

        @(negedge clk);
        chk("hs_ready_T", req_ready, 1'b1);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0B;
        @(negedge clk);
        chk("hs_busy_T1", busy, 1'b1);
        chk("hs_ready_T1", req_ready, 1'b0);
        @(negedge clk);
        chk("hs_busy_T2", busy, 1'b1);
        chk("hs_ready_T2", req_ready, 1'b0);
        chk("hs_resp1_valid", resp_valid, 1'b1);
        chk("hs_resp1_rdata", resp_rdata, 32'hFFFFFFDE);
        req_addr = 32'h08;
        @(negedge clk);
        chk("hs_ready_T3", req_ready, 1'b1);
        chk("hs_busy_T3", busy, 1'b0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("hs_busy_T4", busy, 1'b1);
        chk("hs_addr_T4", mem_addr, 6'h08);
        @(negedge clk);
        chk("hs_resp2_valid", resp_valid, 1'b1);
        chk("hs_resp2_rdata", resp_rdata, 32'hFFFFFFEF);

        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h10;
        req_wdata = 32'hAABBCCDD;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rstmid_mem_we", mem_we, 1'b0);
        chk("rstmid_no_resp", resp_valid, 1'b0);
        chk("rstmid_ready_low", req_ready, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rstmid_ready_after", req_ready, 1'b1);
        chk("rstmid_resp_after", resp_valid, 1'b0);
        chk("rstmid_busy_after", busy, 1'b0);
        chk("rstmid_mem10", mem[16], 8'hDD);
        chk("rstmid_mem11", mem[17], 8'hCC);
        chk("rstmid_mem12", mem[18], 8'h37);
        chk("rstmid_mem13", mem[19], 8'h3A);
        repeat (3) begin
            @(negedge clk);
            chk("rstmid_quiet", resp_valid, 1'b0);
        end

        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lsu_byte_sequencer.md
# lsu_byte_sequencer

Load/store sequencer that sits between the single-cycle core's memory stage and a byte-wide data memory port. It accepts one RV32I load or store request at a time and executes it as a sequence of single-byte memory accesses, one per clock, in little-endian order. Load bytes are assembled and then sign- or zero-extended per funct3. It is the initiating end of the data-memory interface: it drives address, write-enable and write data, and consumes the memory's combinational read data.

## Interface
- ADDR_W, 6, memory byte-address width; request address is taken modulo 2^ADDR_W
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset (sampled on rising edge of clk)
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; accept when req_valid && req_ready
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data (low bytes used for B/H)
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  valid with resp_valid; misaligned or illegal request
- busy  out  1  high in XFER or DONE
- mem_addr  out  ADDR_W  byte address to memory
- mem_we  out  1  byte write strobe, sampled by memory on rising clk
- mem_wdata  out  8  byte to write
- mem_rdata  in  8  combinational read byte at mem_addr

## Operation
- States: IDLE -> XFER -> DONE -> IDLE. Error path: IDLE -> DONE.
- On accept, latch we, funct3, addr[ADDR_W-1:0], wdata; set N = 1/2/4 for B(U)/H(U)/W; clear byte counter k and assembly register.
- Legality: stores allow only funct3 000/001/010; loads allow 000/001/010/100/101. H requires addr[0]=0; W requires addr[1:0]=00. An illegal request goes straight to DONE with resp_err=1, with no memory access and no mem_we.
- XFER, cycle k (0..N-1): mem_addr = (base + k) mod 2^ADDR_W.
  - Store: mem_we=1, mem_wdata = wdata[8k+7:8k].
  - Load: mem_we=0; capture mem_rdata into assembly byte k at the clock edge.
- After byte N-1, go to DONE.
- DONE: resp_valid=1 for exactly one cycle.
  - Load: resp_rdata = assembled value; B/H sign-extend bit 7/15; BU/HU zero-extend; W as-is.
  - Store: resp_rdata=0.
- Outside XFER: mem_we=0, mem_addr=0, mem_wdata=0.
- req_valid while not in IDLE is ignored; the request must be held until accepted.
- Address wrap: the byte index wraps within 2^ADDR_W. Only reachable via upper-bit aliasing, since aligned accesses never straddle the top.

## Timing
- Reset (rst_n low at an edge): state=IDLE, k=0, assembly=0, resp_valid=0, resp_rdata=0, resp_err=0, busy=0, mem_we=0, mem_addr=0, mem_wdata=0. req_ready=0 while rst_n is low and 1 in the first cycle after release.
- Accept at edge of cycle T. XFER occupies cycles T+1..T+N; resp_valid is high in cycle T+N+1; req_ready is high again in T+N+2.
  - Load/store latency: B=2, H=3, W=5 cycles from accept to resp.
  - Error: resp_valid in T+1.
- Back-to-back throughput is one request per N+2 cycles.
- Store bytes commit at the end of each XFER cycle. A later load in the same bench sees all N bytes.
- Reset mid-XFER aborts immediately: no resp_valid, and store bytes already written remain in memory.
- resp_rdata/resp_err hold their DONE values until the next DONE or reset; they are qualified only by resp_valid.

## Test plan
- Store/load word: SW addr 0x08 data 0xDEADBEEF.
  - Store: mem bytes 8..11 = EF,BE,AD,DE; resp_valid at T+5, err=0.
  - LW 0x08: resp_rdata=0xDEADBEEF at T+5.
- Byte/halfword extension (memory from the SW above):
  - LB 0x0B -> 0xFFFFFFDE; LBU 0x0B -> 0x000000DE.
  - LH 0x0A -> 0xFFFFDEAD; LHU 0x08 -> 0x0000BEEF.
  - Each resp at the correct latency.
- Misalignment and illegal funct3:
  - LW 0x09, SH 0x03, and store funct3=100 each give resp_valid at T+1 with err=1 and rdata=0.
  - mem_we stays 0 throughout.
- Address aliasing: SW 0x44 data 0x11223344 writes mem 4..7 = 44,33,22,11; LW 0x04 returns 0x11223344.
- Handshake: hold req_valid high continuously for two LB requests.
  - Second accept occurs exactly at cycle T+3.
  - busy is high in T+1..T+2; req_ready is low in T+1..T+2.
- Reset mid-store: SW 0x10 data 0xAABBCCDD; drive rst_n low during the XFER cycle for k=2.
  - Mem 0x10,0x11 = DD,CC; mem 0x12,0x13 unchanged.
  - No resp_valid; req_ready=1 in the first cycle after release.
